// File: rtl/ram_reader_pkg.sv
// Shared definitions for the RAM stream reader: FSM encoding and FIFO depth.
package ram_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

  // Two entries cover one word in flight plus one word parked behind a stall.
  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/ram_reader_skid_fifo.sv
// Two-entry output FIFO for the RAM stream reader.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module ram_reader_skid_fifo
  import ram_reader_pkg::*;
#(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  // One-bit pointers are enough because the depth is fixed at two.
  logic [FIFO_DEPTH-1:0][WIDTH-1:0] mem;
  logic                             wr_ptr;
  logic                             rd_ptr;
  logic [1:0]                       cnt;
  logic                             do_push;
  logic                             do_pop;

  assign full    = (cnt == 2'd2);
  assign empty   = (cnt == 2'd0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage, pointers and occupancy; push+pop together leaves occupancy unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// RAM read-side controller: turns a (base, count) command into RAM reads and
// returns the words as a valid/ready stream with a last flag.
// Optional feature macro RAM_STREAM_READER_STRIDE_EN adds a per-command
// address stride input (cfg_stride); without it the stride is fixed at 1.
module ram_stream_reader
  import ram_reader_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 12,
  parameter int COUNT_WIDTH  = 13,
  parameter int READ_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  cfg_base_addr,
  input  logic [COUNT_WIDTH-1:0] cfg_num_words,
`ifdef RAM_STREAM_READER_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0]  cfg_stride,
`endif
  output logic                   busy,
  output logic                   done,
  output logic                   s_read_req,
  output logic [ADDR_WIDTH-1:0]  s_read_addr,
  input  logic [DATA_WIDTH-1:0]  s_read_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_last
);

  rd_state_e              state, state_nxt;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [ADDR_WIDTH-1:0]  stride;
  logic [COUNT_WIDTH-1:0] remaining;
  logic                   pop;
  logic                   issue_last;
  logic                   inflight;
  logic                   push;
  logic                   push_last;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [1:0]             occ;
  logic [2:0]             pending;

  assign pop     = m_valid & m_ready;
  assign occ     = fifo_full ? 2'd2 : {1'b0, ~fifo_empty};
  // Words already committed to the FIFO after this cycle's pop; keeping this
  // below two guarantees every returning word has a free slot.
  assign pending = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};

  assign s_read_req  = (state == ISSUE) && (pending < 3'd2);
  assign s_read_addr = addr_q;
  assign issue_last  = s_read_req && (remaining == COUNT_WIDTH'(1));
  assign busy        = (state == ISSUE) || (state == DRAIN);
  assign done        = (state == DONE);

`ifdef RAM_STREAM_READER_STRIDE_EN
  logic [ADDR_WIDTH-1:0] stride_q;

  // Stride is captured with the command so it cannot change mid-transfer.
  always_ff @(posedge clk) begin
    if (reset)                                               stride_q <= '0;
    else if (state == IDLE && start && cfg_num_words != '0) stride_q <= cfg_stride;
  end
  assign stride = stride_q;
`else
  assign stride = ADDR_WIDTH'(1);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; the final handshake implies the FIFO and pipeline are empty.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (cfg_num_words == '0) ? DONE : ISSUE;
      ISSUE:   if (issue_last) state_nxt = DRAIN;
      DRAIN:   if (pop && m_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address and remaining-count tracking; the address wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= '0;
      remaining <= '0;
    end else if (state == IDLE && start && cfg_num_words != '0) begin
      addr_q    <= cfg_base_addr;
      remaining <= cfg_num_words;
    end else if (s_read_req) begin
      addr_q    <= addr_q + stride;
      remaining <= remaining - COUNT_WIDTH'(1);
    end
  end

  generate
    if (READ_LATENCY == 0) begin : g_lat0
      // Combinational RAM: data is valid in the request cycle.
      assign inflight  = 1'b0;
      assign push      = s_read_req;
      assign push_last = issue_last;
    end else begin : g_lat1
      logic inflight_q;
      logic last_q;

      // Registered RAM: remember the request (and its last tag) for one cycle.
      always_ff @(posedge clk) begin
        if (reset) begin
          inflight_q <= 1'b0;
          last_q     <= 1'b0;
        end else begin
          inflight_q <= s_read_req;
          last_q     <= issue_last;
        end
      end
      assign inflight  = inflight_q;
      assign push      = inflight_q;
      assign push_last = last_q;
    end
  endgenerate

  ram_reader_skid_fifo #(.WIDTH(DATA_WIDTH + 1)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({push_last, s_read_data}),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      ({m_last, m_data})
  );

  assign m_valid = ~fifo_empty;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: two instances (READ_LATENCY 1 and 0) share the
// same commands and consumer; a queue model checks reads and output words.
module tb_ram_stream_reader;
  localparam int DW = 16, AW = 12, CW = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, m_ready;
  logic [AW-1:0] base, stride;
  logic [CW-1:0] num;

  logic          busy0, done0, req0, valid0, last0;
  logic          busy1, done1, req1, valid1, last1;
  logic [AW-1:0] raddr0, raddr1;
  logic [DW-1:0] rdata0, rdata1, data0, data1;

  logic [1:0]          busy_a, done_a, req_a, valid_a, last_a;
  logic [1:0][AW-1:0]  raddr_a;
  logic [1:0][DW-1:0]  data_a;
  assign busy_a  = {busy1, busy0};
  assign done_a  = {done1, done0};
  assign req_a   = {req1, req0};
  assign valid_a = {valid1, valid0};
  assign last_a  = {last1, last0};
  assign raddr_a = {raddr1, raddr0};
  assign data_a  = {data1, data0};

  function automatic logic [DW-1:0] ram(input logic [AW-1:0] a);
    return {4'hC, a};
  endfunction

  // RAM models: registered for latency 1, combinational for latency 0.
  initial rdata0 = '0;
  always @(posedge clk) if (req0) rdata0 <= ram(raddr0);
  assign rdata1 = ram(raddr1);

  ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW), .READ_LATENCY(1)) dut0 (
    .clk(clk), .reset(reset), .start(start), .cfg_base_addr(base), .cfg_num_words(num),
`ifdef RAM_STREAM_READER_STRIDE_EN
    .cfg_stride(stride),
`endif
    .busy(busy0), .done(done0), .s_read_req(req0), .s_read_addr(raddr0), .s_read_data(rdata0),
    .m_valid(valid0), .m_ready(m_ready), .m_data(data0), .m_last(last0));

  ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW), .READ_LATENCY(0)) dut1 (
    .clk(clk), .reset(reset), .start(start), .cfg_base_addr(base), .cfg_num_words(num),
`ifdef RAM_STREAM_READER_STRIDE_EN
    .cfg_stride(stride),
`endif
    .busy(busy1), .done(done1), .s_read_req(req1), .s_read_addr(raddr1), .s_read_data(rdata1),
    .m_valid(valid1), .m_ready(m_ready), .m_data(data1), .m_last(last1));

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: expected read addresses and expected output words per instance.
  logic [AW-1:0] exp_addr[2][$];
  logic [AW-1:0] exp_word[2][$];
  bit            pend_done[2];
  bit            prev_stall[2];
  logic [DW-1:0] prev_data[2];

  task automatic clear_model();
    for (int i = 0; i < 2; i++) begin
      exp_addr[i].delete();
      exp_word[i].delete();
      pend_done[i]  = 0;
      prev_stall[i] = 0;
    end
  endtask

  // Compare process: every cycle out of reset.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        if (req_a[i]) begin
          if (exp_addr[i].size() == 0) chk("extra_read", {31'd0, req_a[i]}, 0);
          else chk("read_addr", {20'd0, raddr_a[i]}, {20'd0, exp_addr[i].pop_front()});
        end
        if (prev_stall[i]) begin
          chk("stall_valid", {31'd0, valid_a[i]}, 1);
          chk("stall_data", {16'd0, data_a[i]}, {16'd0, prev_data[i]});
        end
        if (valid_a[i]) begin
          if (exp_word[i].size() == 0) chk("extra_word", {31'd0, valid_a[i]}, 0);
          else begin
            chk("m_data", {16'd0, data_a[i]}, {16'd0, ram(exp_word[i][0])});
            chk("m_last", {31'd0, last_a[i]}, {31'd0, exp_word[i].size() == 1});
            if (m_ready) void'(exp_word[i].pop_front());
          end
        end
        prev_stall[i] = valid_a[i] && !m_ready;
        prev_data[i]  = data_a[i];
        if (done_a[i]) begin
          chk("done_expected", {31'd0, pend_done[i]}, 1);
          chk("done_after_words", exp_word[i].size(), 0);
          pend_done[i] = 0;
        end
      end
    end
  end

  // Drive a one-cycle start pulse and load the model; returns just after the
  // edge that samples start.
  task automatic cmd(input logic [AW-1:0] b, input logic [CW-1:0] n, input logic [AW-1:0] s);
    base = b; num = n; stride = s; start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < int'(n); j++) begin
        exp_addr[i].push_back(AW'(int'(b) + j * int'(s)));
        exp_word[i].push_back(AW'(int'(b) + j * int'(s)));
      end
      pend_done[i] = 1;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Run until both instances report done; mode 1 toggles m_ready 1,0,0,...
  task automatic wait_idle(input int mode);
    for (int c = 0; c < 400 && (pend_done[0] || pend_done[1]); c++) begin
      m_ready = (mode == 1) ? (c % 3 == 0) : 1'b1;
      @(posedge clk); #1;
    end
    chk("cmd_timeout", {30'd0, pend_done[1], pend_done[0]}, 0);
    m_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  logic [8:0] tv[2], tl[2], td[2], tbz[2], treq;
  int first_k[2];

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; start = 1'b0; m_ready = 1'b1; base = '0; num = '0; stride = AW'(1);
    clear_model();
    @(posedge clk); #1;
    @(posedge clk); #1;
    // Reset state
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", {31'd0, busy_a[i]}, 0);
      chk("rst_done", {31'd0, done_a[i]}, 0);
      chk("rst_req", {31'd0, req_a[i]}, 0);
      chk("rst_addr", {20'd0, raddr_a[i]}, 0);
      chk("rst_valid", {31'd0, valid_a[i]}, 0);
      chk("rst_data", {16'd0, data_a[i]}, 0);
      chk("rst_last", {31'd0, last_a[i]}, 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Test 1: base 0x010, 4 words, always ready; hand-computed cycle tables
    // (bit k = k-th negedge after the edge that samples start).
    tv[0] = 9'h078; tl[0] = 9'h040; td[0] = 9'h080; tbz[0] = 9'h07E;
    tv[1] = 9'h03C; tl[1] = 9'h020; td[1] = 9'h040; tbz[1] = 9'h03E;
    treq  = 9'h01E; first_k[0] = 3; first_k[1] = 2;
    cmd(AW'(12'h010), CW'(4), AW'(1));
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk("t1_valid", {31'd0, valid_a[i]}, {31'd0, tv[i][k]});
        chk("t1_last", {31'd0, valid_a[i] & last_a[i]}, {31'd0, tl[i][k]});
        chk("t1_done", {31'd0, done_a[i]}, {31'd0, td[i][k]});
        chk("t1_busy", {31'd0, busy_a[i]}, {31'd0, tbz[i][k]});
        chk("t1_req", {31'd0, req_a[i]}, {31'd0, treq[k]});
        if (tv[i][k]) chk("t1_data", {16'd0, data_a[i]}, {16'd0, 16'hC010 + 16'(k - first_k[i])});
      end
    end
    @(posedge clk); #1;

    // Test 2: same command, consumer toggling ready.
    cmd(AW'(12'h010), CW'(4), AW'(1));
    wait_idle(1);

    // Test 3: address wrap at the top of the RAM.
    cmd(AW'(12'hFFE), CW'(4), AW'(1));
    wait_idle(0);
    chk("t3_wrap_model", {20'd0, AW'(12'hFFE + 12'd3)}, 32'h001);

    // Test 4: zero-count command.
    cmd(AW'(12'h055), CW'(0), AW'(1));
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("t4_done", {31'd0, done_a[i]}, 1);
      chk("t4_busy", {31'd0, busy_a[i]}, 0);
      chk("t4_req", {31'd0, req_a[i]}, 0);
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk("t4_done_once", {31'd0, done_a[i]}, 0);
    @(posedge clk); #1;

    // Test 5: reset in the third ISSUE cycle of an 8-word command.
    cmd(AW'(12'h200), CW'(8), AW'(1));
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    clear_model();
    @(posedge clk); #1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("t5_valid", {31'd0, valid_a[i]}, 0);
      chk("t5_busy", {31'd0, busy_a[i]}, 0);
      chk("t5_done", {31'd0, done_a[i]}, 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    cmd(AW'(12'h100), CW'(2), AW'(1));
    wait_idle(0);

    // Test 6: 16 words, always ready: back-to-back output.
    cmd(AW'(12'h300), CW'(16), AW'(1));
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        chk("t6_stream_valid", {31'd0, valid_a[i]}, {31'd0, (k >= first_k[i]) && (k < first_k[i] + 16)});
    end
    @(posedge clk); #1;
    wait_idle(0);

`ifdef RAM_STREAM_READER_STRIDE_EN
    // Stride 3 with wrap, then stride 0 (same address repeatedly).
    cmd(AW'(12'hFF0), CW'(8), AW'(3));
    wait_idle(1);
    cmd(AW'(12'h0AA), CW'(3), AW'(0));
    wait_idle(0);
`endif

    for (int i = 0; i < 2; i++) begin
      chk("end_reads_left", exp_addr[i].size(), 0);
      chk("end_words_left", exp_word[i].size(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
